// File: rtl/sprite_draw_queue_pkg.sv
// Shared sprite command layout and default widths for the SPI driver, queue and rasteriser.
package sprite_draw_queue_pkg;

   localparam int unsigned DefDepth  = 256;
   localparam int unsigned DefIdW    = 8;
   localparam int unsigned DefCoordW = 16;
   localparam int unsigned DefScaleW = 8;

   typedef struct packed {
      logic [DefIdW-1:0]    id;
      logic [DefCoordW-1:0] x;
      logic [DefCoordW-1:0] y;
      logic [DefScaleW-1:0] scale;
   } sprite_cmd_t;

endpackage

// File: rtl/sprite_draw_queue_if.sv
// Command-receiver / rasteriser side signals of the sprite draw queue.
interface sprite_draw_queue_if import sprite_draw_queue_pkg::*; #(
   parameter int unsigned DEPTH   = DefDepth,
   parameter int unsigned ID_W    = DefIdW,
   parameter int unsigned COORD_W = DefCoordW,
   parameter int unsigned SCALE_W = DefScaleW
) ();

   localparam int unsigned LvlW = $clog2(DEPTH) + 1;

   logic               vsync;
   logic               enq_valid;
   logic               enq_ready;
   logic [ID_W-1:0]    enq_id;
   logic [COORD_W-1:0] enq_x;
   logic [COORD_W-1:0] enq_y;
   logic [SCALE_W-1:0] enq_scale;
   logic               commit;
   logic               dequeue;
   logic               is_empty;
   logic [ID_W-1:0]    sprite_id;
   logic [COORD_W-1:0] sprite_x;
   logic [COORD_W-1:0] sprite_y;
   logic [SCALE_W-1:0] sprite_scale;
   logic               pending;
   logic               overflow;
   logic [LvlW-1:0]    level;

   modport master (
      output vsync, enq_valid, enq_id, enq_x, enq_y, enq_scale, commit, dequeue,
      input  enq_ready, is_empty, sprite_id, sprite_x, sprite_y, sprite_scale, pending,
             overflow, level
   );

   modport slave (
      input  vsync, enq_valid, enq_id, enq_x, enq_y, enq_scale, commit, dequeue,
      output enq_ready, is_empty, sprite_id, sprite_x, sprite_y, sprite_scale, pending,
             overflow, level
   );

endinterface

// File: rtl/sprite_draw_queue_cmd_ram.sv
// Simple dual-port command RAM: synchronous write, asynchronous read.
module sprite_draw_queue_cmd_ram #(
   parameter int unsigned Depth = 256,
   parameter int unsigned Width = 48
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(Depth)-1:0] waddr_i,
   input  logic [Width-1:0]         wdata_i,
   input  logic [$clog2(Depth)-1:0] raddr_i,
   output logic [Width-1:0]         rdata_o
);

   logic [Width-1:0] mem_q [Depth];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sprite_draw_queue.sv
// Frame-coherent sprite command queue: stage, commit, publish on vsync, replay when idle.
module sprite_draw_queue import sprite_draw_queue_pkg::*; #(
   parameter int unsigned DEPTH       = DefDepth,
   parameter int unsigned ID_W        = DefIdW,
   parameter int unsigned COORD_W     = DefCoordW,
   parameter int unsigned SCALE_W     = DefScaleW,
   parameter int unsigned COMMIT_MODE = 1
) (
   input logic                clock,
   input logic                reset,
   sprite_draw_queue_if.slave bus
);

   localparam int unsigned AddrW = $clog2(DEPTH);
   localparam int unsigned PtrW  = AddrW + 1;
   localparam int unsigned CmdW  = ID_W + 2 * COORD_W + SCALE_W;
   localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
   localparam logic [PtrW-1:0] PtrFull = PtrW'(DEPTH);

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] stage_start_q, stage_start_d;
   logic [PtrW-1:0] pend_start_q, pend_start_d;
   logic [PtrW-1:0] pend_end_q, pend_end_d;
   logic [PtrW-1:0] disp_start_q, disp_start_d;
   logic [PtrW-1:0] disp_end_q, disp_end_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic            pend_valid_q, pend_valid_d;
   logic            overflow_q, overflow_d;
   logic            vsync_q, vsync_d;

   logic [PtrW-1:0] used;
   logic            full, empty;
   logic            enq_fire, deq_fire, commit_fire, vs_edge;
   logic [CmdW-1:0] rdata;

   assign used  = wr_ptr_q - disp_start_q;
   assign full  = (used == PtrFull);
   assign empty = (rd_ptr_q == disp_end_q);

   assign enq_fire    = bus.enq_valid && !full;
   assign deq_fire    = bus.dequeue && !empty;
   assign commit_fire = (COMMIT_MODE != 0) && bus.commit;
   assign vs_edge     = (COMMIT_MODE != 0) && bus.vsync && !vsync_q;

   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      stage_start_d = stage_start_q;
      pend_start_d  = pend_start_q;
      pend_end_d    = pend_end_q;
      pend_valid_d  = pend_valid_q;
      disp_start_d  = disp_start_q;
      disp_end_d    = disp_end_q;
      rd_ptr_d      = rd_ptr_q;
      overflow_d    = overflow_q | (bus.enq_valid && full);
      vsync_d       = bus.vsync;

      if (enq_fire) begin
         wr_ptr_d = wr_ptr_q + PtrOne;
      end

      if (COMMIT_MODE != 0) begin
         // Commit first so a same-cycle vsync edge publishes the frame just committed.
         if (commit_fire) begin
            pend_start_d  = stage_start_q;
            pend_end_d    = wr_ptr_d;
            stage_start_d = wr_ptr_d;
            pend_valid_d  = 1'b1;
         end
         if (vs_edge) begin
            if (pend_valid_d) begin
               disp_start_d = pend_start_d;
               disp_end_d   = pend_end_d;
               rd_ptr_d     = pend_start_d;
               pend_valid_d = 1'b0;
            end else begin
               rd_ptr_d = disp_start_q;
            end
         end else if (deq_fire) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
         end
      end else begin
         // Plain FIFO: the displayed window is exactly the unread region.
         if (deq_fire) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
         end
         disp_start_d = rd_ptr_d;
         disp_end_d   = wr_ptr_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q      <= '0;
         stage_start_q <= '0;
         pend_start_q  <= '0;
         pend_end_q    <= '0;
         pend_valid_q  <= 1'b0;
         disp_start_q  <= '0;
         disp_end_q    <= '0;
         rd_ptr_q      <= '0;
         overflow_q    <= 1'b0;
         vsync_q       <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         stage_start_q <= stage_start_d;
         pend_start_q  <= pend_start_d;
         pend_end_q    <= pend_end_d;
         pend_valid_q  <= pend_valid_d;
         disp_start_q  <= disp_start_d;
         disp_end_q    <= disp_end_d;
         rd_ptr_q      <= rd_ptr_d;
         overflow_q    <= overflow_d;
         vsync_q       <= vsync_d;
      end
   end

   sprite_draw_queue_cmd_ram #(
      .Depth(DEPTH),
      .Width(CmdW)
   ) u_ram (
      .clk_i  (clock),
      .we_i   (enq_fire),
      .waddr_i(wr_ptr_q[AddrW-1:0]),
      .wdata_i({bus.enq_id, bus.enq_x, bus.enq_y, bus.enq_scale}),
      .raddr_i(rd_ptr_q[AddrW-1:0]),
      .rdata_o(rdata)
   );

   assign {bus.sprite_id, bus.sprite_x, bus.sprite_y, bus.sprite_scale} = rdata;
   assign bus.enq_ready = !full;
   assign bus.is_empty  = empty;
   assign bus.pending   = pend_valid_q;
   assign bus.overflow  = overflow_q;
   assign bus.level     = used;

endmodule

// File: tb/tb_sprite_draw_queue.sv
// Self-checking bench for sprite_draw_queue: directed scenarios plus random traffic vs a frame model.
module tb_sprite_draw_queue;
   import sprite_draw_queue_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   sprite_draw_queue_if #(.DEPTH(16)) if_m1 ();
   sprite_draw_queue_if #(.DEPTH(4))  if_sm ();
   sprite_draw_queue_if #(.DEPTH(4))  if_ff ();

   sprite_draw_queue #(.DEPTH(16), .COMMIT_MODE(1)) u_m1 (
      .clock(clock), .reset(reset), .bus(if_m1.slave));
   sprite_draw_queue #(.DEPTH(4), .COMMIT_MODE(1)) u_sm (
      .clock(clock), .reset(reset), .bus(if_sm.slave));
   sprite_draw_queue #(.DEPTH(4), .COMMIT_MODE(0)) u_ff (
      .clock(clock), .reset(reset), .bus(if_ff.slave));

   int total = 0;
   int bad   = 0;
   int sel   = 0;

   // Observed outputs of the DUT under test.
   logic        o_empty, o_ready, o_pend, o_ovf;
   int          o_level;
   sprite_cmd_t o_head;

   always_comb begin
      case (sel)
         1: begin
            o_empty = if_sm.is_empty; o_ready = if_sm.enq_ready; o_pend = if_sm.pending;
            o_ovf = if_sm.overflow; o_level = int'(if_sm.level);
            o_head = {if_sm.sprite_id, if_sm.sprite_x, if_sm.sprite_y, if_sm.sprite_scale};
         end
         2: begin
            o_empty = if_ff.is_empty; o_ready = if_ff.enq_ready; o_pend = if_ff.pending;
            o_ovf = if_ff.overflow; o_level = int'(if_ff.level);
            o_head = {if_ff.sprite_id, if_ff.sprite_x, if_ff.sprite_y, if_ff.sprite_scale};
         end
         default: begin
            o_empty = if_m1.is_empty; o_ready = if_m1.enq_ready; o_pend = if_m1.pending;
            o_ovf = if_m1.overflow; o_level = int'(if_m1.level);
            o_head = {if_m1.sprite_id, if_m1.sprite_x, if_m1.sprite_y, if_m1.sprite_scale};
         end
      endcase
   end

   // Reference model: every stored entry from the displayed frame's start onward, as a list.
   sprite_cmd_t mq[$];
   int m_depth, disp_len, rd, pend_off, pend_len, stage_off;
   bit m_mode, pend_valid, m_ovf, vs_prev;

   function automatic bit m_empty();
      return m_mode ? (rd == disp_len) : (mq.size() == 0);
   endfunction

   function automatic sprite_cmd_t m_head();
      return mq[rd];
   endfunction

   function automatic void model_step(bit ev, sprite_cmd_t c, bit cm, bit vs, bit dq);
      bit full   = (mq.size() == m_depth);
      bit ve     = vs && !vs_prev;
      bit deq_ok = m_mode ? (rd < disp_len) : (mq.size() > 0);
      vs_prev = vs;
      if (ev) begin
         if (full) m_ovf = 1'b1;
         else mq.push_back(c);
      end
      if (!m_mode) begin
         if (dq && deq_ok) void'(mq.pop_front());
         return;
      end
      if (cm) begin
         pend_off   = stage_off;
         pend_len   = mq.size() - stage_off;
         stage_off  = mq.size();
         pend_valid = 1'b1;
      end
      if (ve) begin
         if (pend_valid) begin
            repeat (pend_off) void'(mq.pop_front());
            stage_off -= pend_off;
            disp_len   = pend_len;
            pend_valid = 1'b0;
         end
         rd = 0;
      end else if (dq && deq_ok) begin
         rd++;
      end
   endfunction

   function automatic sprite_cmd_t mk(int id);
      sprite_cmd_t c;
      c.id    = 8'(id);
      c.x     = 16'($urandom);
      c.y     = 16'($urandom);
      c.scale = 8'($urandom);
      return c;
   endfunction

   task automatic drive(bit ev, sprite_cmd_t c, bit cm, bit vs, bit dq);
      if_m1.enq_valid = ev && sel == 0; if_m1.commit = cm && sel == 0;
      if_m1.vsync = vs && sel == 0;     if_m1.dequeue = dq && sel == 0;
      {if_m1.enq_id, if_m1.enq_x, if_m1.enq_y, if_m1.enq_scale} = c;
      if_sm.enq_valid = ev && sel == 1; if_sm.commit = cm && sel == 1;
      if_sm.vsync = vs && sel == 1;     if_sm.dequeue = dq && sel == 1;
      {if_sm.enq_id, if_sm.enq_x, if_sm.enq_y, if_sm.enq_scale} = c;
      if_ff.enq_valid = ev && sel == 2; if_ff.commit = cm && sel == 2;
      if_ff.vsync = vs && sel == 2;     if_ff.dequeue = dq && sel == 2;
      {if_ff.enq_id, if_ff.enq_x, if_ff.enq_y, if_ff.enq_scale} = c;
   endtask

   // Called at a falling edge; returns at the next falling edge with inputs idle.
   task automatic step(bit ev, sprite_cmd_t c, bit cm, bit vs, bit dq);
      drive(ev, c, cm, vs, dq);
      @(posedge clock);
      model_step(ev, c, cm, vs, dq);
      @(negedge clock);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(int s, int depth, bit mode);
      sel = s; m_depth = depth; m_mode = mode;
      mq.delete();
      disp_len = 0; rd = 0; pend_off = 0; pend_len = 0; stage_off = 0;
      pend_valid = 0; m_ovf = 0; vs_prev = 0;
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(0, 16, 1'b1);
      total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", o_empty); end
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", o_ready); end
      total++; if (o_level !== 0) begin bad++; $display("FAIL reset_level got=%0d exp=0", o_level); end
      total++; if (o_pend !== 1'b0) begin bad++; $display("FAIL reset_pending got=%0b exp=0", o_pend); end
      total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", o_ovf); end
   endtask

   task automatic test_staging();
      for (int i = 1; i <= 3; i++) step(1'b1, mk(i), 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL stage_empty got=%0b exp=1", o_empty); end
      total++; if (o_pend !== 1'b1) begin bad++; $display("FAIL stage_pending got=%0b exp=1", o_pend); end
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      total++; if (o_pend !== 1'b0) begin bad++; $display("FAIL vs_pending got=%0b exp=0", o_pend); end
      for (int i = 1; i <= 3; i++) begin
         total++;
         if (o_empty !== 1'b0 || o_head !== m_head() || int'(o_head.id) != i) begin
            bad++; $display("FAIL stage_head got=%0d exp=%0d empty=%0b", o_head.id, i, o_empty);
         end
         step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      end
      total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL stage_drained got=%0b exp=1", o_empty); end
   endtask

   task automatic test_replay();
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         total++;
         if (o_empty !== 1'b0 || o_head !== m_head() || int'(o_head.id) != i) begin
            bad++; $display("FAIL replay_head got=%0d exp=%0d empty=%0b", o_head.id, i, o_empty);
         end
         step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      end
      total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL replay_drained got=%0b exp=1", o_empty); end
   endtask

   task automatic test_supersede();
      do_reset(0, 16, 1'b1);
      step(1'b1, mk(10), 1'b0, 1'b0, 1'b0);
      step(1'b1, mk(11), 1'b1, 1'b0, 1'b0);
      step(1'b1, mk(20), 1'b1, 1'b0, 1'b0);
      total++; if (o_level !== 3) begin bad++; $display("FAIL sup_level_pre got=%0d exp=3", o_level); end
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      total++;
      if (o_empty !== 1'b0 || o_head.id !== 8'd20 || o_head !== m_head()) begin
         bad++; $display("FAIL sup_head got=%0d exp=20 empty=%0b", o_head.id, o_empty);
      end
      total++; if (o_level !== 1) begin bad++; $display("FAIL sup_level got=%0d exp=1", o_level); end
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL sup_drained got=%0b exp=1", o_empty); end
      step(1'b1, mk(30), 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1, 1'b0);
      total++;
      if (o_empty !== 1'b0 || o_head.id !== 8'd30 || o_pend !== 1'b0) begin
         bad++; $display("FAIL cm_vs_head got=%0d exp=30 pend=%0b", o_head.id, o_pend);
      end
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      total++;
      if (o_empty !== 1'b0 || o_head.id !== 8'd30) begin
         bad++; $display("FAIL vs_deq_head got=%0d exp=30 empty=%0b", o_head.id, o_empty);
      end
   endtask

   task automatic test_overflow();
      do_reset(1, 4, 1'b1);
      for (int i = 1; i <= 5; i++) step(1'b1, mk(i), 1'b0, 1'b0, 1'b0);
      total++;
      if (o_ready !== 1'b0 || o_ovf !== 1'b1 || o_level !== 4) begin
         bad++; $display("FAIL ovf_full got ready=%0b ovf=%0b level=%0d exp 0/1/4",
                         o_ready, o_ovf, o_level);
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      total++;
      if (o_level !== 4 || o_ready !== 1'b0 || o_head.id !== 8'd1) begin
         bad++; $display("FAIL ovf_disp got level=%0d ready=%0b id=%0d exp 4/0/1",
                         o_level, o_ready, o_head.id);
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      total++;
      if (o_level !== 0 || o_ready !== 1'b1 || o_empty !== 1'b1 || o_ovf !== 1'b1) begin
         bad++; $display("FAIL ovf_freed got level=%0d ready=%0b empty=%0b ovf=%0b exp 0/1/1/1",
                         o_level, o_ready, o_empty, o_ovf);
      end
   endtask

   task automatic test_fifo();
      do_reset(2, 4, 1'b0);
      step(1'b1, mk(5), 1'b0, 1'b0, 1'b0);
      total++;
      if (o_empty !== 1'b0 || o_head.id !== 8'd5 || o_head !== m_head()) begin
         bad++; $display("FAIL fifo_first got=%0d exp=5 empty=%0b", o_head.id, o_empty);
      end
      step(1'b1, mk(6), 1'b0, 1'b0, 1'b1);
      total++;
      if (o_head.id !== 8'd6 || o_level !== 1) begin
         bad++; $display("FAIL fifo_second got id=%0d level=%0d exp 6/1", o_head.id, o_level);
      end
      step(1'b0, '0, 1'b1, 1'b1, 1'b0);
      total++;
      if (o_head.id !== 8'd6 || o_level !== 1 || o_pend !== 1'b0) begin
         bad++; $display("FAIL fifo_ignore got id=%0d level=%0d pend=%0b exp 6/1/0",
                         o_head.id, o_level, o_pend);
      end
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL fifo_drained got=%0b exp=1", o_empty); end
   endtask

   task automatic test_random(int s, int depth, bit mode, int n);
      do_reset(s, depth, mode);
      for (int i = 0; i < n; i++) begin
         total++;
         if (o_empty !== m_empty()) begin
            bad++; $display("FAIL rnd_empty dut=%0d cyc=%0d got=%0b exp=%0b", s, i, o_empty, m_empty());
         end
         total++;
         if (o_ready !== (mq.size() < m_depth)) begin
            bad++; $display("FAIL rnd_ready dut=%0d cyc=%0d got=%0b exp=%0b", s, i, o_ready,
                            mq.size() < m_depth);
         end
         total++;
         if (o_level !== mq.size()) begin
            bad++; $display("FAIL rnd_level dut=%0d cyc=%0d got=%0d exp=%0d", s, i, o_level, mq.size());
         end
         total++;
         if (o_pend !== pend_valid || o_ovf !== m_ovf) begin
            bad++; $display("FAIL rnd_flags dut=%0d cyc=%0d got=%0b%0b exp=%0b%0b", s, i,
                            o_pend, o_ovf, pend_valid, m_ovf);
         end
         if (!m_empty()) begin
            total++;
            if (o_head !== m_head()) begin
               bad++; $display("FAIL rnd_head dut=%0d cyc=%0d got=%h exp=%h", s, i, o_head, m_head());
            end
         end
         step(($urandom % 2) == 0, mk(int'($urandom % 256)), ($urandom % 8) == 0,
              ($urandom % 4) == 0, ($urandom % 5) < 2);
      end
   endtask

   initial begin
      test_reset();
      test_staging();
      test_replay();
      test_supersede();
      test_overflow();
      test_fifo();
      test_random(0, 16, 1'b1, 400);
      test_random(1, 4, 1'b1, 300);
      test_random(2, 4, 1'b0, 300);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_draw_queue.md
# sprite_draw_queue

Parametrised, frame-coherent sprite draw-command queue between the SPI command receiver (write side) and the sprite rasteriser (read side), all in the pixel clock domain. The queue stages commands for the next frame and publishes them atomically on an explicit commit. Publication takes effect on the next vsync rising edge. If no new frame has been committed by that edge, the current frame is replayed so the framebuffer is always redrawn with a complete command list. With `COMMIT_MODE=0` it degrades to a plain first-word-fall-through FIFO.

## Interface
- `DEPTH`, 256: entries; power of two, 4..1024.
- `ID_W`, 8: sprite id width.
- `COORD_W`, 16: x/y width.
- `SCALE_W`, 8: scale width.
- `COMMIT_MODE`, 1: 1 = staged/commit/replay; 0 = plain FIFO.

Ports:
- `clock` in 1: pixel clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `vsync` in 1: frame sync level; rising edge detected internally.
- `enq_valid` in 1: write request.
- `enq_ready` out 1: space available (not full).
- `enq_id`/`enq_x`/`enq_y`/`enq_scale` in ID_W/COORD_W/COORD_W/SCALE_W: command fields.
- `commit` in 1: single-cycle pulse; publishes staged commands as one frame.
- `dequeue` in 1: rasteriser pops the head entry.
- `is_empty` out 1: no displayable entry at the head.
- `sprite_id`/`sprite_x`/`sprite_y`/`sprite_scale` out: head entry; valid while `!is_empty`.
- `pending` out 1: a committed frame awaits vsync.
- `overflow` out 1: sticky; an enqueue was dropped.
- `level` out $clog2(DEPTH)+1: occupied entries, counted from `disp_start` to `wr_ptr`.

## Operation
- Storage: circular LUT-RAM with asynchronous read. Pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- Pointers: `wr_ptr`, `stage_start`, `pend_start`, `pend_end`, `pend_valid`, `disp_start`, `disp_end`, `rd_ptr`. All reset to 0.
- Enqueue: accepted when `enq_valid && enq_ready`. The entry is written at `wr_ptr`, then `wr_ptr` increments.
- Full: `wr_ptr - disp_start == DEPTH`.
  - When full, the entry is dropped and `overflow` is set.
- Commit (mode 1), in this order:
  - `pend_start` ← `stage_start`.
  - `pend_end` ← `wr_ptr` (post-increment if an enqueue is accepted in the same cycle).
  - `stage_start` ← same value as `pend_end`.
  - `pend_valid` ← 1.
- Commit while `pending`: the older pending frame is superseded.
  - Its entries are never displayed.
  - They stay counted in `level` until the next vsync edge.
- Empty commit (nothing staged) publishes an empty frame; the next frame draws nothing.
- Vsync edge (mode 1), when `vsync && !vsync_q`:
  - If `pend_valid`: `disp_start` ← `pend_start`, `disp_end` ← `pend_end`, `rd_ptr` ← `pend_start`, `pend_valid` ← 0. Space before `pend_start` is freed.
  - Otherwise (replay): `rd_ptr` ← `disp_start`.
- Dequeue: `rd_ptr` increments when `dequeue && !is_empty`. A dequeue while empty is ignored.
- `is_empty` = (`rd_ptr == disp_end`).
- Displayed entries are never freed by dequeue; they are freed only when a vsync edge switches frames.
- Mode 0:
  - `commit` and `vsync` are ignored.
  - Dequeue frees the entry.
  - `disp_start` tracks `rd_ptr` and `disp_end` tracks `wr_ptr`.
  - Full condition is `wr_ptr - rd_ptr == DEPTH`.
- Simultaneous events:
  - Commit and vsync in the same cycle: the commit applies first, so the new frame is displayed immediately.
  - Vsync and dequeue in the same cycle: the vsync reload wins.
  - Enqueue and commit in the same cycle: the enqueued entry is included in the commit.
- Reset mid-operation: all pointers, `pend_valid`, `overflow` and `vsync_q` clear. RAM contents are don't-care.

## Timing
- Reset values:
  - `enq_ready` = 1, `is_empty` = 1.
  - `pending` = 0, `overflow` = 0, `level` = 0.
  - Field outputs: don't-care, since `is_empty` = 1.
- Outputs are combinational from registered pointers and RAM; no output depends combinationally on inputs.
- Write-to-read latency, mode 0: the entry is visible on the head outputs the cycle after acceptance.
- Write-to-read latency, mode 1: commit, then the vsync edge clock, then the entry is visible the following cycle.
- Dequeue: the next entry appears on the outputs the cycle after the dequeue.
- Vsync edge: `rd_ptr` is reloaded at the clock where `vsync=1, vsync_q=0`, and the new head is valid the next cycle.
- Throughput: one enqueue and one dequeue per cycle, concurrently.

## Structure
- `params.vh`, or a shared `sprite_pkg` package, carries the `sprite_cmd_t` packed struct (id, x, y, scale) and the default widths shared with the SPI driver and sprite driver.
- One sub-module, `sprite_cmd_ram`: a DEPTH × command-width simple dual-port RAM (sync write, async read).
- Pointer logic and the vsync edge detector live in the top of the block.

## Test plan
- Reset: assert `reset` for 2 cycles.
  - Expect `is_empty=1`, `enq_ready=1`, `level=0`, `pending=0`, `overflow=0`.
- Mode 1 staging: enqueue ids 1,2,3, then pulse `commit`.
  - `is_empty` stays 1 and `pending=1`.
  - After a vsync rising edge: `pending=0`, head id=1; three dequeues yield ids 1,2,3, then `is_empty=1`.
- Replay: another vsync edge with no commit.
  - Head returns to id=1; the same three ids are replayed.
- Supersede and simultaneous: commit frame A (ids 10,11), then frame B (id 20) while pending.
  - On the next vsync edge only id 20 is seen.
  - With a commit on the vsync-edge cycle, frame B displays immediately.
- Overflow, DEPTH=4, mode 1:
  - Enqueue 5 entries without a vsync: the 5th is dropped, `enq_ready=0`, `overflow=1`, `level=4`.
  - Commit, then a vsync edge frees nothing, since the frame is displayed; after the next commit and vsync edge, space reappears.
- Mode 0 FIFO: enqueue ids 5,6 with a dequeue in the same cycle as the second enqueue.
  - Ids come out in order; `commit` and `vsync` have no effect.
